// File: rtl/grid_env_pkg.sv
// grid_env_pkg: shared types and constants for the grid-world stepper.
//   act_e   - action codes carried on the 3-bit act bus (4-7 are illegal)
//   fsm_e   - stepper control states
//   ACT_W   - action bus width
//   DEF_REW_* - default reward values
package grid_env_pkg;

  localparam int unsigned ACT_W = 3;

  typedef enum logic [ACT_W-1:0] {
    ACT_RIGHT = 3'd0,
    ACT_UP    = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_DOWN  = 3'd3
  } act_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACT = 2'd1,
    ST_CALC     = 2'd2,
    ST_RESP     = 2'd3
  } fsm_e;

  localparam int DEF_REW_STEP = -1;
  localparam int DEF_REW_BUMP = -5;
  localparam int DEF_REW_GOAL = 10;

endpackage

// File: rtl/grid_env_stepper_move.sv
// grid_move_calc: combinational move evaluation on a GRID_W x GRID_H grid.
//   cur_state    - agent position (1-based, row-major, row 0 at top)
//   act          - action code
//   blocked_mask - bit s-1 marks state s as an obstacle
//   next_state   - resulting position (cur_state when refused)
//   bump         - move refused (edge, obstacle or illegal code)
//   is_goal      - move accepted and lands on GOAL_STATE
module grid_move_calc
  import grid_env_pkg::*;
#(
  parameter int GRID_W     = 5,
  parameter int GRID_H     = 5,
  parameter int STATE_W    = 6,
  parameter int GOAL_STATE = 25
) (
  input  logic [STATE_W-1:0]       cur_state,
  input  logic [ACT_W-1:0]         act,
  input  logic [GRID_W*GRID_H-1:0] blocked_mask,
  output logic [STATE_W-1:0]       next_state,
  output logic                     bump,
  output logic                     is_goal
);

  localparam int unsigned NCELL = GRID_W * GRID_H;

  logic [STATE_W-1:0] pos;
  logic [STATE_W-1:0] col;
  logic [STATE_W-1:0] row;
  logic [STATE_W-1:0] target;
  logic               edge_hit;
  logic               obstacle;

  always_comb begin
    pos      = cur_state - STATE_W'(1);
    col      = pos % STATE_W'(GRID_W);
    row      = pos / STATE_W'(GRID_W);
    target   = cur_state;
    edge_hit = 1'b0;
    case (act)
      ACT_RIGHT: if (col == STATE_W'(GRID_W - 1)) edge_hit = 1'b1;
                 else target = cur_state + STATE_W'(1);
      ACT_UP:    if (row == '0) edge_hit = 1'b1;
                 else target = cur_state - STATE_W'(GRID_W);
      ACT_LEFT:  if (col == '0) edge_hit = 1'b1;
                 else target = cur_state - STATE_W'(1);
      ACT_DOWN:  if (row == STATE_W'(GRID_H - 1)) edge_hit = 1'b1;
                 else target = cur_state + STATE_W'(GRID_W);
      default:   edge_hit = 1'b1;
    endcase

    // Decoded mask lookup avoids a variable part-select; the goal cell is
    // never treated as blocked.
    obstacle = 1'b0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (!edge_hit && target == STATE_W'(i + 1) &&
          target != STATE_W'(GOAL_STATE))
        obstacle = obstacle | blocked_mask[i];
    end

    bump       = edge_hit | obstacle;
    next_state = bump ? cur_state : target;
    is_goal    = !bump && (next_state == STATE_W'(GOAL_STATE));
  end

endmodule

// File: rtl/grid_env_stepper.sv
// grid_env_stepper: grid-world environment stepper between the policy and
// the Q-table update block.
//   clk, rst_n           - clock, synchronous active-low reset
//   ep_start             - start/restart episode (priority over everything)
//   ep_start_state       - start cell; 0 or out of range selects START_STATE
//   blocked_mask         - per-cell obstacle bits, sampled while calculating
//   act_valid/act_ready  - action handshake, act = action code
//   cur_state            - agent position, 0 when no episode has started
//   out_valid/out_ready  - result handshake
//   next_state, reward, bump, done, truncated, step_cnt - step result
module grid_env_stepper
  import grid_env_pkg::*;
#(
  parameter int GRID_W      = 5,
  parameter int GRID_H      = 5,
  parameter int STATE_W     = 6,
  parameter int START_STATE = 1,
  parameter int GOAL_STATE  = 25,
  parameter int MAX_STEPS   = 64,
  parameter int CNT_W       = 7,
  parameter int REW_W       = 8,
  parameter int REW_STEP    = DEF_REW_STEP,
  parameter int REW_BUMP    = DEF_REW_BUMP,
  parameter int REW_GOAL    = DEF_REW_GOAL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ep_start,
  input  logic [STATE_W-1:0]       ep_start_state,
  input  logic [GRID_W*GRID_H-1:0] blocked_mask,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [ACT_W-1:0]         act,
  output logic [STATE_W-1:0]       cur_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [STATE_W-1:0]       next_state,
  output logic [REW_W-1:0]         reward,
  output logic                     bump,
  output logic                     done,
  output logic                     truncated,
  output logic [CNT_W-1:0]         step_cnt
);

  localparam int NCELL = GRID_W * GRID_H;

  fsm_e               fsm;
  logic [ACT_W-1:0]   act_r;
  logic [STATE_W-1:0] start_sel;
  logic [STATE_W-1:0] mv_next;
  logic               mv_bump;
  logic               mv_goal;
  logic [CNT_W-1:0]   cnt_inc;
  logic               budget_out;

  assign act_ready  = (fsm == ST_WAIT_ACT);
  assign out_valid  = (fsm == ST_RESP);
  assign start_sel  = (ep_start_state == '0 || ep_start_state > STATE_W'(NCELL))
                      ? STATE_W'(START_STATE) : ep_start_state;
  assign cnt_inc    = step_cnt + CNT_W'(1);
  assign budget_out = (cnt_inc == CNT_W'(MAX_STEPS));

  grid_move_calc #(
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H),
    .STATE_W    (STATE_W),
    .GOAL_STATE (GOAL_STATE)
  ) u_move (
    .cur_state    (cur_state),
    .act          (act_r),
    .blocked_mask (blocked_mask),
    .next_state   (mv_next),
    .bump         (mv_bump),
    .is_goal      (mv_goal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm        <= ST_IDLE;
      act_r      <= '0;
      cur_state  <= '0;
      step_cnt   <= '0;
      next_state <= '0;
      reward     <= '0;
      bump       <= 1'b0;
      done       <= 1'b0;
      truncated  <= 1'b0;
    end else if (ep_start) begin
      // Restart from any state drops a pending action or result.
      cur_state <= start_sel;
      step_cnt  <= '0;
      fsm       <= ST_WAIT_ACT;
    end else begin
      case (fsm)
        ST_IDLE: ;
        ST_WAIT_ACT: begin
          if (act_valid) begin
            act_r <= act;
            fsm   <= ST_CALC;
          end
        end
        ST_CALC: begin
          next_state <= mv_next;
          bump       <= mv_bump;
          if (mv_goal)      reward <= REW_W'(REW_GOAL);
          else if (mv_bump) reward <= REW_W'(REW_BUMP);
          else              reward <= REW_W'(REW_STEP);
          done       <= mv_goal | budget_out;
          truncated  <= !mv_goal & budget_out;
          step_cnt   <= cnt_inc;
          fsm        <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            cur_state <= next_state;
            fsm       <= done ? ST_IDLE : ST_WAIT_ACT;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_env_stepper.sv
// Self-checking bench for grid_env_stepper: a coordinate-based reference
// model fills a scoreboard queue at action acceptance; a monitor compares
// every cycle the result is presented and pops on the handshake.
module tb_grid_env_stepper;

  localparam int W     = 5;
  localparam int H     = 5;
  localparam int N     = W * H;
  localparam int GOAL  = 25;
  localparam int MAXS  = 8;

  typedef struct {
    int ns; int rw; int bp; int dn; int tr; int sc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ep_start = 1'b0;
  logic [5:0]   ep_start_state = '0;
  logic [N-1:0] blocked_mask = '0;
  logic         act_valid = 1'b0;
  logic         act_ready;
  logic [2:0]   act = '0;
  logic [5:0]   cur_state;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [5:0]   next_state;
  logic [7:0]   reward;
  logic         bump;
  logic         done;
  logic         truncated;
  logic [6:0]   step_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  int   mcur = 0;
  int   mcnt = 0;
  exp_t last;

  grid_env_stepper #(.MAX_STEPS(MAXS)) dut (
    .clk(clk), .rst_n(rst_n), .ep_start(ep_start),
    .ep_start_state(ep_start_state), .blocked_mask(blocked_mask),
    .act_valid(act_valid), .act_ready(act_ready), .act(act),
    .cur_state(cur_state), .out_valid(out_valid), .out_ready(out_ready),
    .next_state(next_state), .reward(reward), .bump(bump), .done(done),
    .truncated(truncated), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int got, int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, expv, $time);
    end
  endtask

  // Reference: move in (col,row) space, then apply the reward/done rules.
  function automatic exp_t model(int cur, int a, int cnt, logic [N-1:0] mask);
    exp_t e;
    int col, row, nc, nr, tgt;
    bit ok, goal;
    col = (cur - 1) % W;
    row = (cur - 1) / W;
    nc = col; nr = row; ok = 1'b1;
    case (a)
      0: nc = col + 1;
      1: nr = row - 1;
      2: nc = col - 1;
      3: nr = row + 1;
      default: ok = 1'b0;
    endcase
    if (nc < 0 || nc >= W || nr < 0 || nr >= H) ok = 1'b0;
    tgt = nr * W + nc + 1;
    if (ok && tgt != GOAL && mask[tgt-1]) ok = 1'b0;
    goal = ok && (tgt == GOAL);
    e.ns = ok ? tgt : cur;
    e.bp = ok ? 0 : 1;
    e.rw = goal ? 10 : (ok ? -1 : -5);
    e.sc = cnt + 1;
    e.dn = (goal || e.sc == MAXS) ? 1 : 0;
    e.tr = (e.dn == 1 && !goal) ? 1 : 0;
    return e;
  endfunction

  // Monitor: compares the presented result every cycle (covers holding while
  // out_ready is low) and retires it on the handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("next_state", int'(next_state), q[0].ns);
          chk("reward", $signed(reward), q[0].rw);
          chk("bump", int'(bump), q[0].bp);
          chk("done", int'(done), q[0].dn);
          chk("truncated", int'(truncated), q[0].tr);
          chk("step_cnt", int'(step_cnt), q[0].sc);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic start_ep(int s);
    ep_start = 1'b1;
    ep_start_state = 6'(s);
    @(posedge clk); #1;
    ep_start = 1'b0;
    q.delete();
    mcur = (s == 0 || s > N) ? 1 : s;
    mcnt = 0;
    @(negedge clk);
    chk("start_out_valid", int'(out_valid), 0);
    chk("start_cur_state", int'(cur_state), mcur);
    chk("start_step_cnt", int'(step_cnt), 0);
    chk("start_act_ready", int'(act_ready), 1);
    @(posedge clk); #1;
  endtask

  // Offers an action; returns #1 after the accepting edge (DUT in CALC).
  task automatic issue(int a);
    int n = 0;
    act = 3'(a);
    act_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (act_ready) break;
      if (++n > 50) begin
        chk("timeout_act_ready", 0, 1);
        act_valid = 1'b0;
        return;
      end
    end
    last = model(mcur, a, mcnt, blocked_mask);
    q.push_back(last);
    @(posedge clk); #1;
    act_valid = 1'b0;
  endtask

  task automatic recv(int dly);
    int n = 0, seen = 0, first = -1;
    out_ready = (dly == 0);
    forever begin
      @(negedge clk);
      if (out_valid && first < 0) first = n;
      if (out_valid && out_ready) break;
      if (out_valid) seen++;
      if (++n > 60) begin
        chk("timeout_out_valid", 0, 1);
        out_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (seen >= dly) out_ready = 1'b1;
    end
    chk("latency", first, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    mcur = last.ns;
    mcnt = last.sc;
    @(negedge clk);
    chk("post_cur_state", int'(cur_state), mcur);
    chk("post_out_valid", int'(out_valid), 0);
    chk("post_act_ready", int'(act_ready), last.dn ? 0 : 1);
    @(posedge clk); #1;
  endtask

  task automatic step(int a, int dly);
    issue(a);
    @(negedge clk);
    chk("calc_out_valid", int'(out_valid), 0);
    recv(dly);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_act_ready"}, int'(act_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_cur_state"}, int'(cur_state), 0);
    chk({tag, "_next_state"}, int'(next_state), 0);
    chk({tag, "_reward"}, int'(reward), 0);
    chk({tag, "_bump"}, int'(bump), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_truncated"}, int'(truncated), 0);
    chk({tag, "_step_cnt"}, int'(step_cnt), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit active;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic move and latency
    start_ep(1);
    step(0, 0);

    // Edge and illegal-code refusals, out-of-range start selects 1
    start_ep(1);  step(1, 0);
    step(5, 1);
    start_ep(5);  step(0, 0);
    start_ep(21); step(3, 2);
    start_ep(40); step(2, 0);

    // Obstacle at state 7
    blocked_mask = '0;
    blocked_mask[6] = 1'b1;
    start_ep(2); step(3, 0);
    blocked_mask = '0;

    // Goal reached exactly on the last budgeted step: goal, not truncated
    blocked_mask[24] = 1'b1;
    start_ep(1);
    repeat (4) step(0, 0);
    repeat (4) step(3, 0);
    blocked_mask = '0;

    // Budget exhaustion without goal
    start_ep(1);
    repeat (MAXS) step(1, 0);

    // Hold in RESP with out_ready low
    start_ep(1);
    step(0, 5);

    // Restart during RESP drops the result
    start_ep(1);
    issue(0);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("resp_out_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    start_ep(13);

    // Reset while calculating aborts with no output
    issue(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    q.delete();
    @(negedge clk);
    chk_all_zero("midcalc_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mcur = 0; mcnt = 0;
    @(posedge clk); #1;

    // Randomized episodes with sparse random obstacles
    active = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (!active || $urandom_range(0, 19) == 0) begin
        blocked_mask = N'($urandom & $urandom & $urandom);
        start_ep(int'($urandom_range(0, 31)));
        active = 1'b1;
      end
      step(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      if (last.dn == 1) active = 1'b0;
    end

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
